// File: rtl/ising_run_ctrl.sv
// ising_run_ctrl: anneal run sequencer for the Ising core and its sampler.
// A start command runs run_count anneal runs. Each run holds the core in
// reset, releases it for the anneal window, then walks the sampler read
// address over all N spins and streams each captured phase word out.
//
// Result stream handshake: res_valid/res_data/res_spin/res_run/res_last are
// registered and hold stable while res_valid=1 and res_ready=0; a word is
// transferred on a rising clk edge with res_valid&res_ready=1, and res_valid
// drops on the following cycle. The only drop without a transfer is an abort
// or an asynchronous reset.
module ising_run_ctrl #(
    parameter int          N          = 3,
    parameter logic [31:0] PHASE_BASE = 32'd0,
    parameter int          READ_LAT   = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] run_count,
    input  logic [15:0] reset_cycles,
    input  logic [31:0] anneal_cycles,
    input  logic [31:0] host_rd_addr,
    output logic        ising_rstn,
    output logic [31:0] rd_addr,
    input  logic [31:0] phase,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [15:0] res_spin,
    output logic [15:0] res_run,
    output logic        res_last,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RST    = 3'd1;
    localparam logic [2:0] S_ANNEAL = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_PUSH   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [31:0] LAT_M1    = 32'(READ_LAT - 1);
    localparam logic [31:0] LAST_SPIN = 32'(N - 1);

    logic [2:0]  r_state;
    logic [31:0] r_cnt;        // shared cycle counter for RST/ANNEAL/SETTLE
    logic [31:0] r_spin;       // spin currently addressed on rd_addr
    logic [15:0] r_run;        // 0-based run index within the job
    logic [15:0] r_run_count;  // job configuration latched at start
    logic [31:0] r_rst_len;
    logic [31:0] r_ann_len;
    logic        r_res_valid;
    logic [31:0] r_res_data;
    logic [15:0] r_res_spin;
    logic [15:0] r_res_run;
    logic        r_res_last;
    logic        r_aborted;

    logic w_hs;
    logic w_last_spin;
    logic w_last_run;

    assign w_hs        = r_res_valid & res_ready;
    assign w_last_spin = (r_spin == LAST_SPIN);
    assign w_last_run  = (r_run == (r_run_count - 16'd1));

    // Sequencer state, counters, configuration latch and result register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_cnt       <= 32'd0;
            r_spin      <= 32'd0;
            r_run       <= 16'd0;
            r_run_count <= 16'd0;
            r_rst_len   <= 32'd0;
            r_ann_len   <= 32'd0;
            r_res_valid <= 1'b0;
            r_res_data  <= 32'd0;
            r_res_spin  <= 16'd0;
            r_res_run   <= 16'd0;
            r_res_last  <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_aborted <= 1'b0;
            if (abort && (r_state != S_IDLE)) begin
                // Abort drops everything, including a pending result word.
                r_state     <= S_IDLE;
                r_cnt       <= 32'd0;
                r_spin      <= 32'd0;
                r_res_valid <= 1'b0;
                r_aborted   <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // A simultaneous abort cancels the start request.
                        if (start && !abort) begin
                            r_run_count <= run_count;
                            r_rst_len   <= (reset_cycles == 16'd0) ? 32'd1 : {16'd0, reset_cycles};
                            r_ann_len   <= (anneal_cycles == 32'd0) ? 32'd1 : anneal_cycles;
                            r_run       <= 16'd0;
                            r_cnt       <= 32'd0;
                            r_spin      <= 32'd0;
                            r_state     <= (run_count == 16'd0) ? S_DONE : S_RST;
                        end
                    end
                    S_RST: begin
                        if (r_cnt == (r_rst_len - 32'd1)) begin
                            r_cnt   <= 32'd0;
                            r_state <= S_ANNEAL;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    S_ANNEAL: begin
                        if (r_cnt == (r_ann_len - 32'd1)) begin
                            r_cnt   <= 32'd0;
                            r_spin  <= 32'd0;
                            r_state <= S_SETTLE;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    S_SETTLE: begin
                        // rd_addr has been stable READ_LAT cycles: phase is valid now.
                        if (r_cnt == LAT_M1) begin
                            r_cnt       <= 32'd0;
                            r_res_data  <= phase;
                            r_res_spin  <= r_spin[15:0];
                            r_res_run   <= r_run;
                            r_res_last  <= w_last_spin;
                            r_res_valid <= 1'b1;
                            r_state     <= S_PUSH;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    S_PUSH: begin
                        if (w_hs) begin
                            r_res_valid <= 1'b0;
                            if (!w_last_spin) begin
                                r_spin  <= r_spin + 32'd1;
                                r_state <= S_SETTLE;
                            end else if (!w_last_run) begin
                                r_run   <= r_run + 16'd1;
                                r_state <= S_RST;
                            end else begin
                                r_state <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Outputs decoded from state; the core runs only while annealing or reading out.
    always_comb begin
        ising_rstn = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        rd_addr    = host_rd_addr;
        if ((r_state == S_ANNEAL) || (r_state == S_SETTLE) || (r_state == S_PUSH)) begin
            ising_rstn = 1'b1;
        end
        if (r_state != S_IDLE) begin
            busy    = 1'b1;
            rd_addr = PHASE_BASE + r_spin;
        end
        if (r_state == S_DONE) begin
            done = 1'b1;
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_spin  = r_res_spin;
    assign res_run   = r_res_run;
    assign res_last  = r_res_last;
    assign aborted   = r_aborted;
    assign dbg_state = r_state;

endmodule
